// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch (I)
// and data access (D), one outstanding transaction at a time, D prioritised.
module ram_arbiter #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MAX_STREAK  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       owner_wr_q, owner_wr_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] streak_q, streak_d;
  logic       grant_d, grant_i;

  // Grants are gated by resetn so nothing reaches the RAM while reset is held.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (resetn && (state_q == StIdle)) begin
      grant_d = data_req & ~(inst_req & (streak_q == 4'(MAX_STREAK)));
      grant_i = inst_req & ~grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_wr_d   = owner_wr_q;
    lat_cnt_d    = lat_cnt_q;
    streak_d     = streak_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    ram_en       = 1'b0;
    ram_we       = 4'h0;
    ram_addr     = 32'h0;
    ram_wdata    = 32'h0;

    case (state_q)
      StIdle: begin
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
        if (grant_d || grant_i) begin
          ram_en     = 1'b1;
          ram_addr   = grant_d ? data_addr : inst_addr;
          ram_we     = (grant_d && data_wr) ? data_wstrb : 4'h0;
          ram_wdata  = data_wdata;
          state_d    = StWait;
          owner_d    = grant_d;
          owner_wr_d = grant_d & data_wr;
          lat_cnt_d  = 4'(RAM_LATENCY - 1);
          // Only a D win over a waiting I counts towards the starvation limit.
          streak_d   = (grant_d && inst_req) ? streak_q + 4'd1 : 4'd0;
        end
      end
      StWait: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          if (owner_q) begin
            data_data_ok = 1'b1;
            data_rdata   = owner_wr_q ? 32'h0 : ram_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = ram_rdata;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StWait);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      owner_wr_q <= 1'b0;
      lat_cnt_q  <= 4'd0;
      streak_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_wr_q <= owner_wr_d;
      lat_cnt_q  <= lat_cnt_d;
      streak_q   <= streak_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (latency 1 and 3) share stimulus;
// a scoreboard queue predicts each data_ok from the grant that caused it.
module tb_ram_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] rd_val;

  logic        iao [2];
  logic        ido [2];
  logic        dao [2];
  logic        ddo [2];
  logic        ren [2];
  logic        bsy [2];
  logic [31:0] ird [2];
  logic [31:0] drd [2];
  logic [31:0] radr [2];
  logic [31:0] rwd [2];
  logic [3:0]  rwe [2];

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          sel = 0;
  logic [10:0] gseq;
  int          ng;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter #(.RAM_LATENCY(1), .MAX_STREAK(4)) u_lat1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(iao[0]),
    .inst_data_ok(ido[0]), .inst_rdata(ird[0]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(dao[0]),
    .data_data_ok(ddo[0]), .data_rdata(drd[0]),
    .ram_en(ren[0]), .ram_we(rwe[0]), .ram_addr(radr[0]), .ram_wdata(rwd[0]),
    .ram_rdata(rd_val), .busy(bsy[0])
  );

  ram_arbiter #(.RAM_LATENCY(3), .MAX_STREAK(4)) u_lat3 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(iao[1]),
    .inst_data_ok(ido[1]), .inst_rdata(ird[1]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(dao[1]),
    .data_data_ok(ddo[1]), .data_rdata(drd[1]),
    .ram_en(ren[1]), .ram_we(rwe[1]), .ram_addr(radr[1]), .ram_wdata(rwd[1]),
    .ram_rdata(rd_val), .busy(bsy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Settle, retire any data_ok against the queue, then record new grants.
  task automatic score();
    exp_t e;
    int   lat;
    #2;
    lat = (sel != 0) ? 3 : 1;
    if (ido[sel] || ddo[sel]) begin
      if (sb.size() == 0) begin
        chk("spurious_data_ok", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("ok_owner", 32'({ido[sel], ddo[sel]}), e.is_d ? 32'd1 : 32'd2);
        chk("rdata", e.is_d ? drd[sel] : ird[sel], e.rdata);
        chk("other_rdata", e.is_d ? ird[sel] : drd[sel], 32'h0);
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_data_ok", 32'({ido[sel], ddo[sel]}), e.is_d ? 32'd1 : 32'd2);
    end
    if (iao[sel]) sb.push_back('{is_d: 1'b0, rdata: rd_val, due: cyc + lat});
    if (dao[sel]) sb.push_back('{is_d: 1'b1, rdata: data_wr ? 32'h0 : rd_val, due: cyc + lat});
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  // Requests are held high during reset to show nothing is granted.
  task automatic do_reset();
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1;
    sb.delete();
    score();
    chk("rst_busy", 32'(bsy[sel]), 32'd0);
    chk("rst_ram_en", 32'(ren[sel]), 32'd0);
    chk("rst_ram_we", 32'(rwe[sel]), 32'd0);
    chk("rst_addr_ok", 32'({iao[sel], dao[sel]}), 32'd0);
    chk("rst_rdata", ird[sel] | drd[sel], 32'h0);
    tick();
    idle_inputs();
    score();
    tick();
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      score();
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0;
    rd_val = 32'h02C00000;
    idle_inputs();
    @(posedge clk);
    #1;

    // Lone I read, latency 1
    sel = 0;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    score();
    chk("i_addr_ok", 32'(iao[0]), 32'd1);
    chk("i_ram_en", 32'(ren[0]), 32'd1);
    chk("i_ram_addr", radr[0], 32'h1C000000);
    chk("i_ram_we", 32'(rwe[0]), 32'd0);
    chk("i_busy_t", 32'(bsy[0]), 32'd0);
    tick();
    inst_req = 1'b0;
    score();
    chk("i_data_ok", 32'(ido[0]), 32'd1);
    chk("i_busy_t1", 32'(bsy[0]), 32'd1);
    tick();
    score();
    chk("i_busy_t2", 32'(bsy[0]), 32'd0);
    tick();

    // Simultaneous requests: D first, then I
    rd_val = 32'h11112222;
    data_req = 1'b1; data_addr = 32'h100;
    inst_req = 1'b1; inst_addr = 32'h200;
    score();
    chk("sim_d_ack", 32'({iao[0], dao[0]}), 32'd1);
    chk("sim_ram_addr_d", radr[0], 32'h100);
    tick();
    data_req = 1'b0;
    score();
    chk("sim_d_data_ok", 32'(ddo[0]), 32'd1);
    chk("sim_i_wait", 32'(iao[0]), 32'd0);
    tick();
    score();
    chk("sim_i_ack", 32'(iao[0]), 32'd1);
    chk("sim_ram_addr_i", radr[0], 32'h200);
    tick();
    inst_req = 1'b0;
    score();
    chk("sim_i_data_ok", 32'(ido[0]), 32'd1);
    tick();
    drain(1);

    // Starvation limit: both held high
    do_reset();
    rd_val = 32'h33334444;
    gseq = '0;
    ng = 0;
    data_req = 1'b1; data_addr = 32'h500;
    inst_req = 1'b1; inst_addr = 32'h600;
    for (int k = 0; k < 60 && ng < 11; k++) begin
      score();
      if (dao[0]) begin
        gseq[ng] = 1'b1;
        ng++;
      end else if (iao[0]) begin
        gseq[ng] = 1'b0;
        ng++;
      end
      tick();
    end
    chk("streak_grant_count", 32'(ng), 32'd11);
    chk("streak_grant_seq", 32'(gseq), 32'h5EF);
    idle_inputs();
    drain(2);

    // Byte write
    rd_val = 32'h12345678;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0010;
    data_addr = 32'h40; data_wdata = 32'hAABBCCDD;
    score();
    chk("wr_ack", 32'(dao[0]), 32'd1);
    chk("wr_ram_we", 32'(rwe[0]), 32'b0010);
    chk("wr_ram_addr", radr[0], 32'h40);
    chk("wr_ram_wdata", rwd[0], 32'hAABBCCDD);
    tick();
    idle_inputs();
    score();
    chk("wr_data_ok", 32'({ido[0], ddo[0]}), 32'd1);
    chk("wr_rdata_zero", drd[0], 32'h0);
    tick();
    drain(1);

    // Latency 3: D read, then an I request arriving during WAIT
    sel = 1;
    do_reset();
    rd_val = 32'h5A5A0003;
    data_req = 1'b1; data_addr = 32'h80;
    score();
    chk("l3_d_ack", 32'(dao[1]), 32'd1);
    tick();
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h300;
    for (int k = 1; k <= 3; k++) begin
      score();
      chk("l3_i_held", 32'(iao[1]), 32'd0);
      chk("l3_busy", 32'(bsy[1]), 32'd1);
      chk("l3_ram_quiet", radr[1] | rwd[1] | 32'(rwe[1]) | 32'(ren[1]), 32'h0);
      chk("l3_d_ok_timing", 32'(ddo[1]), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    score();
    chk("l3_i_ack_t4", 32'(iao[1]), 32'd1);
    tick();
    inst_req = 1'b0;
    drain(4);
    chk("l3_queue_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a latency-3 read
    data_req = 1'b1; data_addr = 32'h84;
    score();
    chk("rm_d_ack", 32'(dao[1]), 32'd1);
    tick();
    data_req = 1'b0;
    score();
    resetn = 1'b0;
    #1;
    sb.delete();
    chk("rm_busy", 32'(bsy[1]), 32'd0);
    chk("rm_ram_en", 32'(ren[1]), 32'd0);
    chk("rm_oks", 32'({iao[1], ido[1], dao[1], ddo[1]}), 32'd0);
    tick();
    inst_req = 1'b1; data_req = 1'b1;
    score();
    chk("rm_held_ram_en", 32'(ren[1]), 32'd0);
    tick();
    idle_inputs();
    resetn = 1'b1;
    drain(4);
    rd_val = 32'hCAFEF00D;
    inst_req = 1'b1; inst_addr = 32'h1C000010;
    score();
    chk("rm_fresh_ack", 32'(iao[1]), 32'd1);
    tick();
    inst_req = 1'b0;
    drain(4);
    chk("rm_queue_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares one single-port synchronous RAM between the IF-stage instruction fetch (port I, read-only) and the MEM-stage data access (port D, read/write).
- Handles one outstanding transaction at a time, with a fixed configurable RAM latency.
- Port D has priority over port I; a streak limit prevents fetch starvation.
- MEM_ready_go and IF_ready_go are driven from the data_ok pulses of this block.

Parameters:
RAM_LATENCY, 1, cycles from the address cycle (ram_en=1) to valid ram_rdata; legal range 1..15
MAX_STREAK, 4, consecutive D grants allowed while I is pending before I is forced; legal range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  I request; held high until inst_addr_ok
inst_addr  in  32  I byte address
inst_addr_ok  out  1  I request accepted this cycle
inst_data_ok  out  1  I read data valid, one-cycle pulse
inst_rdata  out  32  I read data; 0 when inst_data_ok=0
data_req  in  1  D request; held high until data_addr_ok
data_wr  in  1  1=write, 0=read
data_wstrb  in  4  byte write enables; ignored on reads
data_addr  in  32  D byte address
data_wdata  in  32  D write data
data_addr_ok  out  1  D request accepted this cycle
data_data_ok  out  1  D transaction complete (read data valid, or write done), one-cycle pulse
data_rdata  out  32  D read data; 0 unless data_data_ok=1 for a read
ram_en  out  1  RAM access strobe
ram_we  out  4  RAM byte write enables
ram_addr  out  32  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data
busy  out  1  a transaction is outstanding (state WAIT)

Behaviour:
- FSM has two states, IDLE and WAIT; it resets to IDLE.
- Registered state: state, owner (0=I, 1=D), owner_wr, lat_cnt[3:0], streak[3:0].
- Reset values: all registered state is 0. busy, all *_ok outputs, ram_en, ram_we and the rdata outputs read 0 during and after reset.

Arbitration (combinational, in IDLE only):
- grant_d = data_req & ~(inst_req & streak==MAX_STREAK).
- grant_i = inst_req & ~grant_d.
- Nothing is granted in WAIT; requests stay pending.

Grant cycle T (in IDLE):
- Assert the winner's *_addr_ok in cycle T.
- Drive ram_en=1 and ram_addr = the winner's address in cycle T.
- ram_we = data_wstrb if D writes, else 0. ram_wdata = data_wdata.
- When not granting, ram_en=0, ram_we=0, ram_addr=0 and ram_wdata=0.
- On the edge: state<=WAIT, owner latched, owner_wr latched, lat_cnt<=RAM_LATENCY-1.

streak update (on the grant edge):
- D granted while inst_req=1: streak<=streak+1.
- I granted, or D granted while inst_req=0: streak<=0.
- streak never exceeds MAX_STREAK.

WAIT:
- If lat_cnt!=0: lat_cnt decrements.
- If lat_cnt==0 (cycle T+RAM_LATENCY): pulse the owner's *_data_ok.
  - The owner's rdata = ram_rdata, passed through combinationally; for a D write, rdata=0.
  - On the edge, state<=IDLE.
- The earliest next grant is cycle T+RAM_LATENCY+1, so throughput is one access per RAM_LATENCY+1 cycles.

Other rules:
- Simultaneous inst_req and data_req with streak<MAX_STREAK: D wins and I stays pending.
- A requester dropping req before addr_ok is legal; nothing is issued for it.
- Requests arriving in WAIT are not acknowledged until IDLE.
- resetn asserted mid-transaction: the transaction is aborted immediately and asynchronously, and no data_ok is generated for it.
- After resetn deasserts, the first rising edge can grant.

Test Plan:
- Lone I read, RAM_LATENCY=1: inst_req, addr 0x1C000000 at T → inst_addr_ok and ram_en at T; inst_data_ok at T+1 with inst_rdata=ram_rdata (0x02C00000); busy=1 at T+1 only.
- Simultaneous requests: data_req read 0x100 and inst_req 0x200 at T → data_addr_ok at T, data_data_ok at T+1; inst_addr_ok at T+2, inst_data_ok at T+3.
- Starvation, MAX_STREAK=4: data_req and inst_req held high → D granted 4 times, 5th grant goes to I, then D resumes; the streak count restarts at 0.
- Byte write: data_wr=1, data_wstrb=4'b0010, addr 0x40, data_wdata 0xAABBCCDD → ram_we=4'b0010 at T; data_data_ok at T+1 with data_rdata=0; inst_data_ok stays 0.
- RAM_LATENCY=3: D read at T → data_data_ok only at T+3; a new inst_req at T+1 is acknowledged at T+4.
- Reset mid-operation: resetn low at T+1 of a RAM_LATENCY=3 read → busy, ram_en and all *_ok go to 0 immediately; no data_ok ever appears for that read; after release a fresh I read completes normally.
